// File: rtl/pixel_result_writer.sv
// pixel_result_writer: buffers solver results in a small FIFO, drains them as Avalon-MM writes and pulses tile_done per completed tile
module pixel_result_writer #(
  parameter int FIFO_DEPTH_BITS = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_addr,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        cfg_wr_en,
  input  logic [15:0] cfg_tile_pixels,
  output logic [31:0] avm_address,
  output logic [15:0] avm_writedata,
  output logic        avm_write,
  input  logic        avm_waitrequest,
  output logic        tile_done,
  output logic        busy
);
  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  logic [31:0] mem_addr [DEPTH];
  logic [15:0] mem_data [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_BITS:0] occ;
  logic [15:0] count, tile_pixels;
  logic [31:0] head_addr;
  logic empty, push, pop;
  // occupancy never exceeds DEPTH, so its MSB alone marks full
  always_comb begin
    empty = occ == '0;
    in_ready = !occ[FIFO_DEPTH_BITS];
    push = in_valid && in_ready;
    avm_write = !empty;
    pop = avm_write && !avm_waitrequest;
    head_addr = mem_addr[rd_ptr];
    avm_address = empty ? '0 : BASE_ADDR + {head_addr[30:0], 1'b0};
    avm_writedata = empty ? '0 : mem_data[rd_ptr];
    busy = !empty || count != '0;
  end
  always_ff @(posedge clock)
    if (push) begin
      mem_addr[wr_ptr] <= in_addr;
      mem_data[wr_ptr] <= in_data;
    end
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + FIFO_DEPTH_BITS'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + FIFO_DEPTH_BITS'(1) : rd_ptr;
      occ <= push && !pop ? occ + (FIFO_DEPTH_BITS+1)'(1) :
             pop && !push ? occ - (FIFO_DEPTH_BITS+1)'(1) : occ;
    end
  end
  // a config load takes priority over counting a same-cycle pop
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
      tile_pixels <= '0;
      tile_done <= 1'b0;
    end else begin
      tile_done <= 1'b0;
      if (cfg_wr_en) begin
        tile_pixels <= cfg_tile_pixels;
        count <= '0;
      end else if (pop) begin
        if (tile_pixels != '0 && count + 16'd1 == tile_pixels) begin
          count <= '0;
          tile_done <= 1'b1;
        end else begin
          count <= count + 16'd1;
        end
      end
    end
  end
endmodule
